// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared widths, IR field layout, FS codes and FSM states
// Purpose: common definitions for fu_issue_ctrl, fu_regfile and the function unit.
// Ports: none (package).
package fu_pkg;

    localparam int DATA_W   = 10;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 1 << REG_AW;
    localparam int FS_W     = 5;
    localparam int SH_W     = 5;
    localparam int IR_W     = FS_W + 3 * REG_AW + SH_W;

    // IR = {FS[18:14], DR[13:11], SA[10:8], SB[7:5], SH[4:0]}
    localparam int IR_FS_LSB = 14;
    localparam int IR_DR_LSB = 11;
    localparam int IR_SA_LSB = 8;
    localparam int IR_SB_LSB = 5;
    localparam int IR_SH_LSB = 0;

    // Function-select codes understood by the function unit. This block
    // forwards FS opaquely; the codes live here so both sides agree.
    localparam logic [FS_W-1:0] FS_MOVA = 5'b00000;
    localparam logic [FS_W-1:0] FS_INC  = 5'b00001;
    localparam logic [FS_W-1:0] FS_ADD  = 5'b00010;
    localparam logic [FS_W-1:0] FS_SUB  = 5'b00101;
    localparam logic [FS_W-1:0] FS_DEC  = 5'b00110;
    localparam logic [FS_W-1:0] FS_AND  = 5'b01000;
    localparam logic [FS_W-1:0] FS_OR   = 5'b01010;
    localparam logic [FS_W-1:0] FS_XOR  = 5'b01100;
    localparam logic [FS_W-1:0] FS_NOT  = 5'b01110;
    localparam logic [FS_W-1:0] FS_MOVB = 5'b10000;
    localparam logic [FS_W-1:0] FS_SHR  = 5'b10100;
    localparam logic [FS_W-1:0] FS_SHL  = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic [FS_W-1:0] ir_fs(input logic [IR_W-1:0] ir);
        return ir[IR_FS_LSB +: FS_W];
    endfunction

    function automatic logic [REG_AW-1:0] ir_dr(input logic [IR_W-1:0] ir);
        return ir[IR_DR_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] ir_sa(input logic [IR_W-1:0] ir);
        return ir[IR_SA_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] ir_sb(input logic [IR_W-1:0] ir);
        return ir[IR_SB_LSB +: REG_AW];
    endfunction

    function automatic logic [SH_W-1:0] ir_sh(input logic [IR_W-1:0] ir);
        return ir[IR_SH_LSB +: SH_W];
    endfunction

endpackage

// File: rtl/fu_regfile.sv
// rtl/fu_regfile.sv - 8 x DATA_W register file, R0 hard zero
// Purpose: operand storage for fu_issue_ctrl.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset (clears all)
//   i_we, i_waddr, i_wdata  synchronous write port (writes to R0 dropped)
//   i_raddr_a / o_rdata_a   combinational read port A
//   i_raddr_b / o_rdata_b   combinational read port B
//   i_dbg_addr / o_dbg_data combinational debug read port
module fu_regfile
    import fu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Reset has priority so a write in flight during reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // R0 is masked on read as well, so it is zero regardless of storage.
    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/fu_issue_ctrl.sv
// rtl/fu_issue_ctrl.sv - issue/write-back controller for the 10-bit function unit
// Purpose: accepts IR words, drives the function unit operands, commits F and flags.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_ir_valid, o_ir_ready, i_ir  instruction handshake, IR = {FS,DR,SA,SB,SH}
//   o_fu_a, o_fu_b, o_fu_sh, o_fu_fs  registered function unit inputs
//   i_fu_f, i_fu_z/c/n/v       function unit result and flags
//   o_done                     one-cycle pulse in the write-back cycle
//   o_status                   {V,C,N,Z} of the last committed instruction
//   i_dbg_sel, o_dbg_data      combinational register file peek
module fu_issue_ctrl
    import fu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ir_valid,
    output logic              o_ir_ready,
    input  logic [IR_W-1:0]   i_ir,
    output logic [DATA_W-1:0] o_fu_a,
    output logic [DATA_W-1:0] o_fu_b,
    output logic [SH_W-1:0]   o_fu_sh,
    output logic [FS_W-1:0]   o_fu_fs,
    input  logic [DATA_W-1:0] i_fu_f,
    input  logic              i_fu_z,
    input  logic              i_fu_c,
    input  logic              i_fu_n,
    input  logic              i_fu_v,
    output logic              o_done,
    output logic [3:0]        o_status,
    input  logic [REG_AW-1:0] i_dbg_sel,
    output logic [DATA_W-1:0] o_dbg_data
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_commit;

    logic [DATA_W-1:0] r_fu_a;
    logic [DATA_W-1:0] r_fu_b;
    logic [SH_W-1:0]   r_fu_sh;
    logic [FS_W-1:0]   r_fu_fs;
    logic [REG_AW-1:0] r_dr;
    logic [3:0]        r_status;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Operands are read straight from the IR fields so they can be latched
    // on the accept edge. No bypass: a commit always lands before the next accept.
    fu_regfile u_regfile (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_we       (w_commit),
        .i_waddr    (r_dr),
        .i_wdata    (i_fu_f),
        .i_raddr_a  (ir_sa(i_ir)),
        .o_rdata_a  (w_rd_a),
        .i_raddr_b  (ir_sb(i_ir)),
        .o_rdata_b  (w_rd_b),
        .i_dbg_addr (i_dbg_sel),
        .o_dbg_data (o_dbg_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ir_ready   = 1'b0;
        o_done       = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ir_ready = 1'b1;
                if (i_ir_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Function unit has had the whole cycle to settle on r_fu_*.
                w_commit     = 1'b1;
                w_next_state = ST_WB;
            end
            ST_WB: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Function unit inputs hold between accepts so the result stays observable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fu_a   <= '0;
            r_fu_b   <= '0;
            r_fu_sh  <= '0;
            r_fu_fs  <= '0;
            r_dr     <= '0;
            r_status <= '0;
        end else begin
            if (w_accept) begin
                r_fu_a  <= w_rd_a;
                r_fu_b  <= w_rd_b;
                r_fu_sh <= ir_sh(i_ir);
                r_fu_fs <= ir_fs(i_ir);
                r_dr    <= ir_dr(i_ir);
            end
            // Flags commit even when DR=0 discards the result.
            if (w_commit) begin
                r_status <= {i_fu_v, i_fu_c, i_fu_n, i_fu_z};
            end
        end
    end

    assign o_fu_a   = r_fu_a;
    assign o_fu_b   = r_fu_b;
    assign o_fu_sh  = r_fu_sh;
    assign o_fu_fs  = r_fu_fs;
    assign o_status = r_status;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb/tb_fu_issue_ctrl.sv - directed self-checking bench for fu_issue_ctrl
module tb_fu_issue_ctrl;
    import fu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ir_valid;
    logic              ir_ready;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] fu_a;
    logic [DATA_W-1:0] fu_b;
    logic [SH_W-1:0]   fu_sh;
    logic [FS_W-1:0]   fu_fs;
    logic [DATA_W-1:0] fu_f;
    logic              fz, fc, fn, fv;
    logic              done;
    logic [3:0]        status;
    logic [REG_AW-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    // Function unit model: F = A + B unless the bench forces a value.
    logic              force_f;
    logic [DATA_W-1:0] f_val;
    assign fu_f = force_f ? f_val : (fu_a + fu_b);

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fu_issue_ctrl dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_ir_valid (ir_valid),
        .o_ir_ready (ir_ready),
        .i_ir       (ir),
        .o_fu_a     (fu_a),
        .o_fu_b     (fu_b),
        .o_fu_sh    (fu_sh),
        .o_fu_fs    (fu_fs),
        .i_fu_f     (fu_f),
        .i_fu_z     (fz),
        .i_fu_c     (fc),
        .i_fu_n     (fn),
        .i_fu_v     (fv),
        .o_done     (done),
        .o_status   (status),
        .i_dbg_sel  (dbg_sel),
        .o_dbg_data (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IR_W-1:0] mk_ir(input logic [4:0] fs, input logic [2:0] dr,
                                              input logic [2:0] sa, input logic [2:0] sb,
                                              input logic [4:0] sh);
        return {fs, dr, sa, sb, sh};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic peek(input logic [2:0] sel, input logic [9:0] exp, input string tag);
        dbg_sel = sel;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issue one instruction from an IDLE negedge, leaving the bench at the EXEC negedge.
    task automatic issue(input logic [IR_W-1:0] word);
        ir       = word;
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
    endtask

    logic [IR_W-1:0]   prog   [4];
    logic [DATA_W-1:0] exp_a  [4];

    initial begin
        reset = 1'b1; ir_valid = 1'b0; ir = '0; dbg_sel = '0;
        force_f = 1'b0; f_val = '0; fz = 0; fc = 0; fn = 0; fv = 0;

        // Reset held two cycles
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_ready",  ir_ready, 1);
        chk("rst_done",   done,     0);
        chk("rst_status", status,   0);
        chk("rst_fu_a",   fu_a,     0);
        chk("rst_fu_b",   fu_b,     0);
        chk("rst_fu_sh",  fu_sh,    0);
        chk("rst_fu_fs",  fu_fs,    0);
        for (int i = 0; i < 8; i++) peek(i[2:0], 10'h000, "rst_dbg");

        // Reset dominates a valid instruction
        reset = 1'b1; ir_valid = 1'b1; ir = mk_ir(5'b10101, 3'd5, 3'd0, 3'd0, 5'd7);
        step();
        reset = 1'b0; ir_valid = 1'b0;
        #1;
        chk("rstv_ready", ir_ready, 1);
        chk("rstv_fs",    fu_fs,    0);

        // Reset in the EXEC cycle of a write to R5
        force_f = 1'b1; f_val = 10'h077; fz = 1; fc = 1; fn = 1; fv = 1;
        issue(mk_ir(5'b00010, 3'd5, 3'd0, 3'd0, 5'd0));
        chk("mid_exec_ready", ir_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_ready",  ir_ready, 1);
        chk("mid_done",   done,     0);
        chk("mid_status", status,   0);
        peek(3'd5, 10'h000, "mid_r5");
        step();
        chk("mid_done2",  done,     0);
        chk("mid_ready2", ir_ready, 1);
        fz = 0; fc = 0; fn = 0; fv = 0;

        // Preload R1=5, R2=3
        f_val = 10'h005;
        issue(mk_ir(5'b00000, 3'd1, 3'd0, 3'd0, 5'd0));
        step(); chk("pre1_done", done, 1);
        step(); peek(3'd1, 10'h005, "pre1_r1");
        f_val = 10'h003;
        issue(mk_ir(5'b00000, 3'd2, 3'd0, 3'd0, 5'd0));
        step(); chk("pre2_done", done, 1);
        step(); peek(3'd2, 10'h003, "pre2_r2");

        // Basic op: R3 = R1 + R2
        force_f = 1'b0;
        issue(mk_ir(5'b00010, 3'd3, 3'd1, 3'd2, 5'd4));
        chk("op_fs",    fu_fs,    5'b00010);
        chk("op_sh",    fu_sh,    4);
        chk("op_a",     fu_a,     10'h005);
        chk("op_b",     fu_b,     10'h003);
        chk("op_ready", ir_ready, 0);
        chk("op_done0", done,     0);
        ir = mk_ir(5'b11111, 3'd7, 3'd7, 3'd7, 5'd31);
        step();
        chk("op_done",   done,     1);
        chk("op_ready1", ir_ready, 0);
        chk("op_fs_hold", fu_fs,   5'b00010);
        peek(3'd3, 10'h008, "op_r3");
        step();
        chk("op_done_end", done,   0);
        chk("op_ready2", ir_ready, 1);
        peek(3'd7, 10'h000, "op_r7_untouched");

        // R0 target with Z=1, C=1
        fz = 1; fc = 1;
        issue(mk_ir(5'b00010, 3'd0, 3'd1, 3'd2, 5'd0));
        step();
        chk("r0_done",   done,   1);
        chk("r0_status", status, 4'b0101);
        peek(3'd0, 10'h000, "r0_read");
        step();
        fz = 0; fc = 0;

        // Flag capture: V=1, N=1, F=200
        force_f = 1'b1; f_val = 10'h200; fv = 1; fn = 1;
        issue(mk_ir(5'b01010, 3'd4, 3'd2, 3'd1, 5'd9));
        step();
        chk("flg_status", status, 4'b1010);
        peek(3'd4, 10'h200, "flg_r4");
        step();
        fv = 0; fn = 0; fz = 1; fc = 1;
        step(); step();
        chk("flg_hold",   status, 4'b1010);
        chk("fu_a_hold",  fu_a,   10'h003);
        chk("fu_sh_hold", fu_sh,  9);
        fz = 0; fc = 0; force_f = 1'b0;

        // Back-to-back with IR_VALID held; each SA chases the previous DR
        prog[0] = mk_ir(5'b00010, 3'd5, 3'd1, 3'd2, 5'd1);  exp_a[0] = 10'h005;
        prog[1] = mk_ir(5'b00010, 3'd6, 3'd5, 3'd1, 5'd2);  exp_a[1] = 10'h008;
        prog[2] = mk_ir(5'b00010, 3'd7, 3'd6, 3'd6, 5'd3);  exp_a[2] = 10'h00D;
        prog[3] = mk_ir(5'b00010, 3'd1, 3'd7, 3'd0, 5'd4);  exp_a[3] = 10'h01A;
        ir_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk("b2b_ready", ir_ready, (c % 3) == 0);
            chk("b2b_done",  done,     (c % 3) == 2);
            if ((c % 3) == 0) ir = prog[c / 3];
            if ((c % 3) == 1) begin
                chk("b2b_fu_a", fu_a, exp_a[c / 3]);
                ir = mk_ir(5'b11111, 3'd2, 3'd3, 3'd4, 5'd31);
            end
            step();
        end
        ir_valid = 1'b0;
        chk("b2b_end_ready", ir_ready, 1);
        peek(3'd5, 10'h008, "b2b_r5");
        peek(3'd6, 10'h00D, "b2b_r6");
        peek(3'd7, 10'h01A, "b2b_r7");
        peek(3'd1, 10'h01A, "b2b_r1");
        peek(3'd2, 10'h003, "b2b_r2");
        step();
        chk("b2b_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
